// File: rtl/exp_share_arbiter.sv
// Shares one fixed-latency exponent unit among NUM_REQ lanes. Results are tagged with
// the issuing lane and sit in a credit-protected FIFO. Define EXP_ARB_FIXED_PRIO_EN to
// let the lowest-index lane always win instead of round-robin.
`timescale 1ns/1ps
module exp_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int EXP_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [7:0]             exp_in,
  input  logic [7:0]             exp_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic [ID_W-1:0]        rsp_id
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      data;
  } rsp_t;

  logic [CW-1:0]                count_q, count_d, occ_q, occ_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EXP_LAT-1:0]           vld_pipe_q, vld_pipe_d;
  logic [EXP_LAT-1:0][ID_W-1:0] id_pipe_q, id_pipe_d;
  rsp_t                         mem_q [FIFO_DEPTH];
  logic                         issue_ok, grant, push, pop;
  logic [ID_W-1:0]              gnt_id;

  // Gating on resetn keeps req_ready low while reset is held, not just after an edge.
  assign issue_ok = resetn && (count_q < DEPTH_C);

`ifdef EXP_ARB_FIXED_PRIO_EN
  always_comb begin
    grant  = 1'b0;
    gnt_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) begin
        grant  = issue_ok;
        gnt_id = ID_W'(i);
      end
  end
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  int              rr_idx;

  // Scan offsets high to low so the nearest valid lane at/after the pointer wins last.
  always_comb begin
    grant  = 1'b0;
    gnt_id = '0;
    rr_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (req_valid[rr_idx]) begin
        grant  = issue_ok;
        gnt_id = ID_W'(rr_idx);
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign req_ready = grant ? (NUM_REQ'(1) << gnt_id) : '0;
  assign exp_in    = grant ? req_data[8*int'(gnt_id) +: 8] : 8'h00;

  assign push      = vld_pipe_q[EXP_LAT-1];
  assign rsp_valid = (occ_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q].data : 8'h00;
  assign rsp_id    = rsp_valid ? mem_q[rd_ptr_q].id   : '0;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    id_pipe_d     = id_pipe_q;
    vld_pipe_d[0] = grant;
    id_pipe_d[0]  = gnt_id;
    for (int i = 1; i < EXP_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      id_pipe_d[i]  = id_pipe_q[i-1];
    end

    // Credits cover both in-flight ops and buffered results.
    count_d = count_q;
    case ({grant, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q    <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      count_q    <= count_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{id: id_pipe_q[EXP_LAT-1], data: exp_out};
  end
endmodule
